// File: rtl/minimac2_pkg.sv
// Shared definitions for the minimac2 toggle pulse-transfer link (transmit and receive sides).
package minimac2_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

    localparam int unsigned CNT_WIDTH_DEF   = 4;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // Fewer than two stages cannot resolve metastability, so smaller requests are clamped.
    function automatic int unsigned sync_depth(input int unsigned stages);
        return (stages < 2) ? 2 : stages;
    endfunction

endpackage

// File: rtl/minimac2_pulse_tx_if.sv
// Event/handshake bundle of minimac2_pulse_tx; master is the transmitter's view.
// Timeout signals exist only when MINIMAC2_PULSE_TX_TIMEOUT_EN is defined.
interface minimac2_pulse_tx_if #(
    parameter int unsigned CNT_WIDTH = minimac2_pkg::CNT_WIDTH_DEF
);
    logic                 i;
    logic                 ack_toggle;
    logic                 req_toggle;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] pending;
    logic                 overflow;
    logic                 overflow_clr;
`ifdef MINIMAC2_PULSE_TX_TIMEOUT_EN
    logic                 timeout;
    logic                 timeout_clr;
`endif

    modport master (
        input  i, ack_toggle, overflow_clr,
`ifdef MINIMAC2_PULSE_TX_TIMEOUT_EN
        input  timeout_clr,
        output timeout,
`endif
        output req_toggle, busy, done, pending, overflow
    );

    modport slave (
        output i, ack_toggle, overflow_clr,
`ifdef MINIMAC2_PULSE_TX_TIMEOUT_EN
        output timeout_clr,
        input  timeout,
`endif
        input  req_toggle, busy, done, pending, overflow
    );

endinterface

// File: rtl/minimac2_sync_ff.sv
// Single-bit multi-flop synchronizer with synchronous active-low reset to 0.
module minimac2_sync_ff
    import minimac2_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam int unsigned DEPTH = sync_depth(STAGES);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], d};
    end

    // NOTE: every stage is reset so a stale far-end level cannot masquerade as an ack after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/minimac2_pulse_tx.sv
// Initiator of the toggle req/ack pulse link: queues event pulses and issues one req edge per event.
// Optional ack-wait timeout flag enabled by defining MINIMAC2_PULSE_TX_TIMEOUT_EN.
module minimac2_pulse_tx
    import minimac2_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
`ifdef MINIMAC2_PULSE_TX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT     = 1024
`endif
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    minimac2_pulse_tx_if.master bus
);

    localparam logic [CNT_WIDTH-1:0] PEND_MAX = '1;

    state_e               state_q, state_d;
    logic                 req_q, req_d;
    logic [CNT_WIDTH-1:0] pending_q, pending_d;
    logic                 overflow_q, overflow_d;

    logic ack_s;
    logic ack_match;
    logic issue;
    logic dec;
    logic drop;

    minimac2_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (bus.ack_toggle),
        .q     (ack_s)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        drop       = 1'b0;

        ack_match = (state_q == WAIT_ACK) && (ack_s == req_q);
        issue     = (state_q == IDLE) && (bus.i || (pending_q != '0));
        dec       = issue && (pending_q != '0);

        case (state_q)
            IDLE: begin
                if (issue) begin
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_match) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An event arriving while idle either issues directly or replaces the one dequeued.
        if (bus.i && !issue) begin
            if (pending_q == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (dec && !bus.i) begin
            pending_d = pending_q - 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef MINIMAC2_PULSE_TX_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;
    logic            timeout_set;

    // Counter parks at its last value; the ack is still awaited and req_toggle is never retracted.
    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        timeout_set = (state_q == WAIT_ACK) && (wait_cnt_q == TO_LAST);

        if (issue) begin
            wait_cnt_d = '0;
        end else if ((state_q == WAIT_ACK) && (wait_cnt_q != TO_LAST)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if (timeout_set) begin
            timeout_d = 1'b1;
        end else if (bus.timeout_clr) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`endif

    // done is decoded from flops only, in the last WAIT_ACK cycle, so it never meets an issue.
    assign bus.req_toggle = req_q;
    assign bus.busy       = (state_q == WAIT_ACK);
    assign bus.done       = ack_match;
    assign bus.pending    = pending_q;
    assign bus.overflow   = overflow_q;

endmodule
